periph_bcd_feeder: RTL and testbench
====================================

// Module: periph_bcd_feeder
// PURPOSE
//  Bus master that sits upstream of the 4-digit seven-segment peripheral.
//  - Accepts a 16-bit binary value and converts it to 4 BCD digits (iterative double-dabble).
//  - Writes the digits into the display's digit registers (dig1..dig4) over the peripheral bus.
//  - Frees the CPU from software BCD conversion and multi-write sequences.
// PARAMETERS
//  DATA_WIDTH   `PERIPH_DATA_WIDTH  peripheral bus data width (>=4)
//  ADDR_WIDTH   `PERIPH_ADDR_WIDTH  peripheral bus address width
//  DIG_BASE     4                   register index of dig1 (thousands); dig2..dig4 follow at +1..+3
//  TIMEOUT      15                  cycles to wait for bus_ready per write before aborting (1..255)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  value        in   16          binary value to display
//  value_valid  in   1           request; accepted when value_valid & ~busy
//  busy         out  1           high from accept until done (or abort)
//  done         out  1           1-cycle pulse: all 4 digits written
//  err          out  1           1-cycle pulse: bus timeout, sequence aborted
//  ovf          out  1           sticky: last accepted value > 9999; cleared on next accept
//  bus_addr     out  ADDR_WIDTH  peripheral register index
//  bus_data     out  DATA_WIDTH  write data; digit zero-extended
//  bus_write    out  1           write strobe
//  bus_read     out  1           tied 0 (block never reads)
//  bus_ready    in   1           peripheral ack, sampled on posedge while bus_write=1
// BEHAVIOUR
//  Reset
//  - State IDLE. busy/done/err/ovf/bus_write/bus_read = 0; bus_addr = 0; bus_data = 0.
//  - Reset mid-sequence abandons it immediately; a half-written display is acceptable.
//  States
//  - IDLE -> CONV on accept. Latch value; clear ovf; busy=1 next cycle.
//  - CONV: 16 cycles, one shift-add-3 step per cycle on a 16+16-bit shift register. Then -> WR.
//  - WR: bus_write=1, bus_addr=DIG_BASE+k, bus_data={0,digit[k]}. k=0 thousands .. k=3 units.
//    - On bus_ready=1: -> GAP, bus_write=0 from the next cycle.
//    - Otherwise count the wait. After TIMEOUT cycles with no ready: -> IDLE, err pulse, bus_write=0.
//  - GAP: 1 idle cycle with bus_write=0. Then k++ -> WR, or after k=3 -> DONE.
//  - DONE: done=1 for 1 cycle, busy=0 in the same cycle. -> IDLE.
//  Overflow
//  - If the latched value > 9999: ovf=1, and all four digits are written as 4'hF
//    (display shows its blank/error pattern). Conversion result is discarded.
//  Handshake
//  - value_valid while busy is ignored; there is no queueing.
//  - Accept is possible in the cycle after DONE (back-to-back).
//  - bus_addr/bus_data are stable for the whole time bus_write=1.
//  Latency (bus_ready tied 1, as the display returns ready=write)
//  - Accept at cycle 0. CONV cycles 1..16. Writes at 17,19,21,23. GAPs at 18,20,22,24.
//  - done=1 at cycle 25.
//  Arithmetic
//  - BCD nibble adjust: +3 when the nibble >=5, before each shift; no carry between nibbles.
//  - Digits are 4 bits, zero-extended to DATA_WIDTH.
// STRUCTURE
//  - constants.v gains:
//    - `PERIPH_7SEG_DIG_BASE (4)
//    - `BCD_BLANK (4'hF)
//    - state encodings `FEED_IDLE/CONV/WR/GAP/DONE (3 bits)
//  - One sub-module, bcd_double_dabble:
//    - ports: clk, rst, start, bin[15:0], busy, valid, bcd[15:0]
//    - 16-cycle serial converter
//  - The top level holds the FSM, the digit counter, the timeout counter and the bus outputs.
// TESTING
//  1. value=1234, bus_ready=bus_write
//     -> writes (4,1),(5,2),(6,3),(7,4) at cycles 17/19/21/23; done at 25; ovf=0.
//  2. value=0
//     -> four writes of data 0; value=9999 -> four writes of data 9; ovf=0 both.
//  3. value=10000 (and 65535)
//     -> ovf=1; four writes of data 4'hF; done pulses.
//  4. bus_ready held 0 on the 2nd write
//     -> bus_write high 15 cycles at addr 5; then err pulse, busy=0, no done, no write to 6/7.
//  5. value_valid held high with 42, then 7
//     -> 42 written; the request during busy is ignored; 7 accepted the cycle after done.
//  6. rst asserted at cycle 18 (mid-write)
//     -> next cycle all outputs 0, IDLE; a fresh request completes normally.

Source files
------------

// File: rtl/periph_bcd_feeder_pkg.sv
// Shared constants and the double-dabble step function for the BCD feeder.
// The feeder writes converted digits into the seven-segment peripheral.
package periph_bcd_feeder_pkg;

  localparam int PERIPH_DATA_WIDTH    = 8;
  localparam int PERIPH_ADDR_WIDTH    = 8;
  localparam int PERIPH_7SEG_DIG_BASE = 4;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [2:0] FEED_IDLE = 3'd0;
  localparam logic [2:0] FEED_CONV = 3'd1;
  localparam logic [2:0] FEED_WR   = 3'd2;
  localparam logic [2:0] FEED_GAP  = 3'd3;
  localparam logic [2:0] FEED_DONE = 3'd4;

  // One shift-add-3 iteration: adjust the four BCD nibbles held in [31:16],
  // then shift the whole BCD:binary register left by one bit.
  function automatic logic [31:0] dd_step(input logic [31:0] sr);
    logic [31:0] t;
    t = sr;
    for (int i = 0; i < 4; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) begin
        t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
      end
    end
    return {t[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/periph_bcd_feeder_bcd_double_dabble.sv
// Serial 16-bit binary to 4-digit BCD converter, one double-dabble step per cycle.
// valid pulses for one cycle once bcd holds the finished result.
module bcd_double_dabble
  import periph_bcd_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        valid,
  output logic [15:0] bcd
);

  logic [31:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  // The first step is folded into the load so the full 16 steps finish
  // 16 cycles after start, with valid landing in the 16th cycle.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (start) begin
      sr_d   = dd_step({16'h0000, bin});
      cnt_d  = 4'd15;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = dd_step(sr_q);
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign bcd   = sr_q[31:16];

endmodule

// File: rtl/periph_bcd_feeder.sv
// Bus master that converts a binary value to BCD and writes the four digits
// into the seven-segment peripheral's digit registers.
module periph_bcd_feeder
  import periph_bcd_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = PERIPH_DATA_WIDTH,
  parameter int ADDR_WIDTH = PERIPH_ADDR_WIDTH,
  parameter int DIG_BASE   = PERIPH_7SEG_DIG_BASE,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value,
  input  logic                  value_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_write,
  output logic                  bus_read,
  input  logic                  bus_ready
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        dd_start;
  logic        dd_busy;
  logic        dd_valid;
  logic [15:0] dd_bcd;
  logic [15:0] bcd_shifted;
  logic [3:0]  digit_val;

  bcd_double_dabble u_dd (
    .clk   (clk),
    .rst   (rst),
    .start (dd_start),
    .bin   (value),
    .busy  (dd_busy),
    .valid (dd_valid),
    .bcd   (dd_bcd)
  );

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    wait_d   = wait_q;
    err_d    = 1'b0;
    ovf_d    = ovf_q;
    dd_start = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (value_valid) begin
          dd_start = 1'b1;
          ovf_d    = (value > 16'd9999);
          digit_d  = 2'd0;
          state_d  = FEED_CONV;
        end
      end
      FEED_CONV: begin
        if (dd_valid && !dd_busy) begin
          wait_d  = 8'd0;
          state_d = FEED_WR;
        end
      end
      FEED_WR: begin
        if (bus_ready) begin
          state_d = FEED_GAP;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FEED_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      FEED_GAP: begin
        if (digit_q == 2'd3) begin
          state_d = FEED_DONE;
        end else begin
          digit_d = digit_q + 2'd1;
          wait_d  = 8'd0;
          state_d = FEED_WR;
        end
      end
      FEED_DONE: state_d = FEED_IDLE;
      default:   state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FEED_IDLE;
      digit_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Digit 0 is the thousands nibble; overflowed values show the blank pattern.
  assign bcd_shifted = dd_bcd >> {2'd3 - digit_q, 2'b00};
  assign digit_val   = ovf_q ? BCD_BLANK : bcd_shifted[3:0];

  always_comb begin
    bus_addr = '0;
    bus_data = '0;
    if (state_q == FEED_WR) begin
      bus_addr      = ADDR_WIDTH'(DIG_BASE) + ADDR_WIDTH'(digit_q);
      bus_data[3:0] = digit_val;
    end
  end

  assign bus_write = (state_q == FEED_WR);
  assign bus_read  = 1'b0;
  assign busy      = (state_q == FEED_CONV) || (state_q == FEED_WR) || (state_q == FEED_GAP);
  assign done      = (state_q == FEED_DONE);
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_periph_bcd_feeder.sv
// Directed testbench for periph_bcd_feeder with hand-computed digit writes and cycle timing.
module tb_periph_bcd_feeder;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        value_valid;
  logic        busy, done, err, ovf;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_write, bus_read, bus_ready;
  logic        stall_addr5;

  int checks;
  int errors;

  int          wr_count;
  int          wr_cyc[8];
  logic [7:0]  wr_addr_a[8];
  logic [7:0]  wr_data_a[8];
  int          done_cyc, err_cyc, max_run;
  logic        unstable, busy_c1, busy_end, ovf_end;

  periph_bcd_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ovf         (ovf),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .bus_write   (bus_write),
    .bus_read    (bus_read),
    .bus_ready   (bus_ready)
  );

  assign bus_ready = bus_write & ~(stall_addr5 & (bus_addr == 8'd5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise a request for one accept edge; the next negedge is cycle 1.
  task automatic start_request(input logic [15:0] v);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
  endtask

  // Record write events (one per rising bus_write) until done/err or the budget expires.
  task automatic capture(input int max_cycles);
    int   run;
    logic prev;
    run = 0; prev = 1'b0;
    wr_count = 0; done_cyc = -1; err_cyc = -1; max_run = 0;
    unstable = 1'b0; busy_c1 = 1'b0; busy_end = 1'b1; ovf_end = 1'b0;
    for (int n = 1; n <= max_cycles; n++) begin
      @(negedge clk);
      if (n == 1) busy_c1 = busy;
      if (bus_write) begin
        if (!prev) begin
          if (wr_count < 8) begin
            wr_cyc[wr_count]    = n;
            wr_addr_a[wr_count] = bus_addr;
            wr_data_a[wr_count] = bus_data;
          end
          wr_count++;
          run = 0;
        end else if (wr_count <= 8) begin
          if (bus_addr !== wr_addr_a[wr_count-1] || bus_data !== wr_data_a[wr_count-1])
            unstable = 1'b1;
        end
        run++;
        if (run > max_run) max_run = run;
      end
      prev = bus_write;
      if (done || err) begin
        if (done) done_cyc = n;
        if (err)  err_cyc  = n;
        busy_end = busy;
        ovf_end  = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (err !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    if (ovf !== 1'b0)       begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    if (bus_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", bus_write); end
    if (bus_read !== 1'b0)  begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", bus_read); end
    if (bus_addr !== 8'd0)  begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus_addr); end
    if (bus_data !== 8'd0)  begin errors++; $display("[TB] FAIL reset_data: got %0d expected 0", bus_data); end
    rst = 1'b0;
  endtask

  task automatic test_basic_1234();
    logic [7:0] exp_d[4];
    exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
    start_request(16'd1234);
    capture(45);
    checks += 5;
    if (busy_c1 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_c1: got %b expected 1", busy_c1); end
    if (wr_count != 4)    begin errors++; $display("[TB] FAIL basic_wr_count: got %0d expected 4", wr_count); end
    if (done_cyc != 25)   begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 25", done_cyc); end
    if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy_end); end
    if (ovf_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf_end); end
    for (int k = 0; k < 4 && k < wr_count; k++) begin
      checks += 3;
      if (wr_cyc[k] != 17 + 2*k) begin errors++; $display("[TB] FAIL basic_wr%0d_cycle: got %0d expected %0d", k, wr_cyc[k], 17 + 2*k); end
      if (wr_addr_a[k] !== 8'(4 + k)) begin errors++; $display("[TB] FAIL basic_wr%0d_addr: got %0d expected %0d", k, wr_addr_a[k], 4 + k); end
      if (wr_data_a[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL basic_wr%0d_data: got %0d expected %0d", k, wr_data_a[k], exp_d[k]); end
    end
  endtask

  task automatic test_zero_and_max();
    logic [15:0] vals[2];
    logic [7:0]  digs[2];
    vals = '{16'd0, 16'd9999};
    digs = '{8'd0, 8'd9};
    for (int t = 0; t < 2; t++) begin
      start_request(vals[t]);
      capture(45);
      checks += 3;
      if (wr_count != 4)   begin errors++; $display("[TB] FAIL edge%0d_wr_count: got %0d expected 4", vals[t], wr_count); end
      if (done_cyc != 25)  begin errors++; $display("[TB] FAIL edge%0d_done_cycle: got %0d expected 25", vals[t], done_cyc); end
      if (ovf_end !== 1'b0) begin errors++; $display("[TB] FAIL edge%0d_ovf: got %b expected 0", vals[t], ovf_end); end
      for (int k = 0; k < 4 && k < wr_count; k++) begin
        checks++;
        if (wr_data_a[k] !== digs[t]) begin errors++; $display("[TB] FAIL edge%0d_wr%0d_data: got %0d expected %0d", vals[t], k, wr_data_a[k], digs[t]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] vals[2];
    vals = '{16'd10000, 16'd65535};
    for (int t = 0; t < 2; t++) begin
      start_request(vals[t]);
      capture(45);
      checks += 3;
      if (wr_count != 4)    begin errors++; $display("[TB] FAIL ovf%0d_wr_count: got %0d expected 4", vals[t], wr_count); end
      if (done_cyc != 25)   begin errors++; $display("[TB] FAIL ovf%0d_done_cycle: got %0d expected 25", vals[t], done_cyc); end
      if (ovf_end !== 1'b1) begin errors++; $display("[TB] FAIL ovf%0d_flag: got %b expected 1", vals[t], ovf_end); end
      for (int k = 0; k < 4 && k < wr_count; k++) begin
        checks++;
        if (wr_data_a[k] !== 8'h0F) begin errors++; $display("[TB] FAIL ovf%0d_wr%0d_data: got %0h expected f", vals[t], k, wr_data_a[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    stall_addr5 = 1'b1;
    start_request(16'd1234);
    capture(60);
    checks += 7;
    if (wr_count != 2)   begin errors++; $display("[TB] FAIL tmo_wr_count: got %0d expected 2", wr_count); end
    if (wr_addr_a[1] !== 8'd5) begin errors++; $display("[TB] FAIL tmo_addr: got %0d expected 5", wr_addr_a[1]); end
    if (max_run != 15)   begin errors++; $display("[TB] FAIL tmo_write_len: got %0d expected 15", max_run); end
    if (unstable !== 1'b0) begin errors++; $display("[TB] FAIL tmo_stable: got %b expected 0", unstable); end
    if (err_cyc != 34)   begin errors++; $display("[TB] FAIL tmo_err_cycle: got %0d expected 34", err_cyc); end
    if (done_cyc != -1)  begin errors++; $display("[TB] FAIL tmo_no_done: got %0d expected -1", done_cyc); end
    if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL tmo_busy: got %b expected 0", busy_end); end
    stall_addr5 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_write !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_quiet: got write=%b err=%b expected 0/0", bus_write, err); end
    end
  endtask

  task automatic test_back_to_back();
    int         dc, wc;
    int         dcyc[2];
    int         wcyc[8];
    logic [7:0] wdat[8];
    logic [7:0] exp_d[8];
    int         exp_c[8];
    logic       b26, b27;
    exp_d = '{8'd0, 8'd0, 8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'd7};
    exp_c = '{17, 19, 21, 23, 43, 45, 47, 49};
    dc = 0; wc = 0; b26 = 1'b1; b27 = 1'b0;
    dcyc = '{-1, -1};
    @(negedge clk);
    value = 16'd42;
    value_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60 && dc < 2; n++) begin
      @(negedge clk);
      if (bus_write && wc < 8) begin wcyc[wc] = n; wdat[wc] = bus_data; wc++; end
      if (n == 26) b26 = busy;
      if (n == 27) begin b27 = busy; value_valid = 1'b0; end
      if (done) begin
        dcyc[dc] = n;
        dc++;
        if (dc == 1) value = 16'd7;
      end
    end
    value_valid = 1'b0;
    checks += 5;
    if (wc != 8)         begin errors++; $display("[TB] FAIL b2b_wr_count: got %0d expected 8", wc); end
    if (dcyc[0] != 25)   begin errors++; $display("[TB] FAIL b2b_done1: got %0d expected 25", dcyc[0]); end
    if (dcyc[1] != 51)   begin errors++; $display("[TB] FAIL b2b_done2: got %0d expected 51", dcyc[1]); end
    if (b26 !== 1'b0)    begin errors++; $display("[TB] FAIL b2b_busy26: got %b expected 0", b26); end
    if (b27 !== 1'b1)    begin errors++; $display("[TB] FAIL b2b_busy27: got %b expected 1", b27); end
    for (int k = 0; k < wc; k++) begin
      checks += 2;
      if (wdat[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL b2b_wr%0d_data: got %0d expected %0d", k, wdat[k], exp_d[k]); end
      if (wcyc[k] != exp_c[k])  begin errors++; $display("[TB] FAIL b2b_wr%0d_cycle: got %0d expected %0d", k, wcyc[k], exp_c[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d[4];
    exp_d = '{8'd5, 8'd6, 8'd7, 8'd8};
    start_request(16'hFFFF);
    for (int n = 1; n <= 18; n++) @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ovf_before: got %b expected 1", ovf); end
    rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (bus_write !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_write: got %b expected 0", bus_write); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    if (ovf !== 1'b0)       begin errors++; $display("[TB] FAIL rstmid_ovf: got %b expected 0", ovf); end
    if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pulses: got done=%b err=%b expected 0/0", done, err); end
    if (bus_addr !== 8'd0)  begin errors++; $display("[TB] FAIL rstmid_addr: got %0d expected 0", bus_addr); end
    if (bus_data !== 8'd0)  begin errors++; $display("[TB] FAIL rstmid_data: got %0d expected 0", bus_data); end
    rst = 1'b0;
    start_request(16'd5678);
    capture(45);
    checks += 2;
    if (wr_count != 4)  begin errors++; $display("[TB] FAIL rstmid_wr_count: got %0d expected 4", wr_count); end
    if (done_cyc != 25) begin errors++; $display("[TB] FAIL rstmid_done_cycle: got %0d expected 25", done_cyc); end
    for (int k = 0; k < 4 && k < wr_count; k++) begin
      checks++;
      if (wr_data_a[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL rstmid_wr%0d_data: got %0d expected %0d", k, wr_data_a[k], exp_d[k]); end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    value       = 16'd0;
    value_valid = 1'b0;
    stall_addr5 = 1'b0;
    test_reset();
    test_basic_1234();
    test_zero_and_max();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
